// File: rtl/window_line_buffer_pkg.sv
// Shared definitions for the window line buffer and the downstream kernel multiplier.
package window_line_buffer_pkg;

  localparam int PIX_W      = 8;
  localparam int FILT_WIDTH = 3;
  localparam int WIN_N      = FILT_WIDTH * FILT_WIDTH;
  localparam int WIN_W      = WIN_N * PIX_W;

  // Slot index inside the packed window: slot WIN_N-1 is top-left, slot 0 is bottom-right.
  function automatic int win_slot(input int r, input int c);
    return WIN_N - 1 - (r * FILT_WIDTH + c);
  endfunction

endpackage

// File: rtl/window_line_buffer_if.sv
// Pixel-stream input and window output bundle of the window line buffer.
interface window_line_buffer_if;
  import window_line_buffer_pkg::*;

  logic             sof;
  logic [PIX_W-1:0] pixIn;
  logic             pixValid;
  logic [WIN_W-1:0] FilterBuffer;
  logic             enable;
  logic             frameDone;

  // Upstream side drives pixels and observes windows.
  modport master (
    output sof, pixIn, pixValid,
    input  FilterBuffer, enable, frameDone
  );

  // The line buffer consumes pixels and produces windows.
  modport slave (
    input  sof, pixIn, pixValid,
    output FilterBuffer, enable, frameDone
  );

endinterface

// File: rtl/window_line_buffer_line_buffer.sv
// One image line of storage: 1R1W RAM with registered read. A read and a write to the
// same address in the same cycle return the old contents.
module line_buffer #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/window_line_buffer.sv
// Builds FILT_WIDTH x FILT_WIDTH neighbourhoods from a raster pixel stream using
// FILT_WIDTH-1 chained line buffers and a shifting window register array.
module window_line_buffer
  import window_line_buffer_pkg::*;
#(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256
) (
  input logic                 clk,
  input logic                 rst,
  window_line_buffer_if.slave bus
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  logic [COL_W-1:0] col_reg, col_next, col_cur;
  logic [ROW_W-1:0] row_reg, row_next, row_cur;
  logic             accept, last_col, last_row, win_valid;
  logic             enable_reg, frame_done_reg;

  logic [PIX_W-1:0] win_reg [FILT_WIDTH][FILT_WIDTH];
  logic [PIX_W-1:0] new_col [FILT_WIDTH];
  logic [PIX_W-1:0] lb_rd   [FILT_WIDTH-1];
  logic [PIX_W-1:0] lb_wr   [FILT_WIDTH-1];
  logic [WIN_W-1:0] filter_buffer;

  // Position of the incoming pixel (sof restarts at the origin) and next counter state.
  always_comb begin
    accept    = bus.pixValid && !rst;
    col_cur   = (bus.sof && bus.pixValid) ? '0 : col_reg;
    row_cur   = (bus.sof && bus.pixValid) ? '0 : row_reg;
    last_col  = (col_cur == COL_W'(IMG_WIDTH - 1));
    last_row  = (row_cur == ROW_W'(IMG_HEIGHT - 1));
    win_valid = accept && (row_cur >= ROW_W'(FILT_WIDTH - 1)) &&
                (col_cur >= COL_W'(FILT_WIDTH - 1));
    col_next  = col_reg;
    row_next  = row_reg;
    if (rst) begin
      col_next = '0;
      row_next = '0;
    end else if (accept) begin
      col_next = last_col ? '0 : col_cur + 1'b1;
      row_next = row_cur;
      if (last_col) begin
        row_next = last_row ? '0 : row_cur + 1'b1;
      end
    end
  end

  // Raster position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  // Line buffer chain: buffer 0 stores the current line, buffer k the line k rows above.
  // Reads are prefetched at col_next so the data for a column is ready when its pixel
  // arrives; after a sof the prefetch can be stale, but only for rows the row gate masks.
  genvar gi;
  generate
    for (gi = 0; gi < FILT_WIDTH - 1; gi++) begin : g_lb
      if (gi == 0) begin : g_first
        assign lb_wr[gi] = bus.pixIn;
      end else begin : g_chain
        assign lb_wr[gi] = lb_rd[gi-1];
      end

      line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W)
      ) u_line_buffer (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (col_cur),
        .wr_data (lb_wr[gi]),
        .rd_addr (col_next),
        .rd_data (lb_rd[gi])
      );

      assign new_col[FILT_WIDTH-2-gi] = lb_rd[gi];
    end
  endgenerate

  assign new_col[FILT_WIDTH-1] = bus.pixIn;

  // Window shift: every accepted pixel moves the window one column left.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < FILT_WIDTH; r++) begin
        for (int c = 0; c < FILT_WIDTH; c++) begin
          win_reg[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < FILT_WIDTH; r++) begin
        for (int c = 0; c < FILT_WIDTH - 1; c++) begin
          win_reg[r][c] <= win_reg[r][c+1];
        end
        win_reg[r][FILT_WIDTH-1] <= new_col[r];
      end
    end
  end

  // Output strobes: window valid and end of frame, one cycle after the pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      enable_reg     <= win_valid;
      frame_done_reg <= accept && last_col && last_row;
    end
  end

  // Pack the window registers into slot order.
  always_comb begin
    filter_buffer = '0;
    for (int r = 0; r < FILT_WIDTH; r++) begin
      for (int c = 0; c < FILT_WIDTH; c++) begin
        filter_buffer[win_slot(r, c)*PIX_W +: PIX_W] = win_reg[r][c];
      end
    end
  end

  assign bus.FilterBuffer = filter_buffer;
  assign bus.enable       = enable_reg;
  assign bus.frameDone    = frame_done_reg;

endmodule

// File: tb/tb_window_line_buffer.sv
// Scoreboard bench for window_line_buffer: an 8x8 and a 5x3 instance driven in turn.
module tb_window_line_buffer;
  import window_line_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  window_line_buffer_if bus0();
  window_line_buffer_if bus1();

  window_line_buffer #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  window_line_buffer #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int               d;
    logic [WIN_W-1:0] win;
    int unsigned      cyc;
  } exp_t;

  exp_t q_win[$];
  exp_t q_fd[$];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt[2];
  int fd_cnt[2];
  bit prev_en[2];
  bit toggle_chk = 1'b0;
  logic [WIN_W-1:0] got0[$];
  logic [WIN_W-1:0] got1[$];

  // Reference model: image storage and raster position per instance.
  logic [7:0] img[2][8][8];
  int mrow[2];
  int mcol[2];
  int W[2] = '{8, 5};
  int H[2] = '{8, 3};

  task automatic chk(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic model_accept(input int d, input bit s, input logic [7:0] p);
    int r;
    int c;
    int slot;
    logic [WIN_W-1:0] w;
    if (s) begin
      mrow[d] = 0;
      mcol[d] = 0;
    end
    r = mrow[d];
    c = mcol[d];
    img[d][r][c] = p;
    if (r >= 2 && c >= 2) begin
      w = '0;
      for (int rr = 0; rr < 3; rr++) begin
        for (int cc = 0; cc < 3; cc++) begin
          slot = 8 - (rr * 3 + cc);
          w[slot*8 +: 8] = img[d][r-2+rr][c-2+cc];
        end
      end
      q_win.push_back('{d: d, win: w, cyc: cyc});
    end
    if (r == H[d] - 1 && c == W[d] - 1) q_fd.push_back('{d: d, win: '0, cyc: cyc});
    mcol[d] = (c == W[d] - 1) ? 0 : c + 1;
    if (c == W[d] - 1) mrow[d] = (r == H[d] - 1) ? 0 : r + 1;
  endtask

  task automatic mon(input int d, input logic [WIN_W-1:0] fb, input logic en, input logic fd);
    exp_t e;
    bit exp_en;
    bit exp_fd;
    exp_en = (q_win.size() > 0 && q_win[0].d == d && q_win[0].cyc == cyc);
    exp_fd = (q_fd.size() > 0 && q_fd[0].d == d && q_fd[0].cyc == cyc);
    if (exp_en || en === 1'b1) chk($sformatf("enable_dut%0d", d), WIN_W'(en), WIN_W'(exp_en));
    if (exp_en) begin
      e = q_win.pop_front();
      if (en === 1'b1) chk($sformatf("window_dut%0d", d), fb, e.win);
    end
    if (exp_fd || fd === 1'b1) chk($sformatf("frameDone_dut%0d", d), WIN_W'(fd), WIN_W'(exp_fd));
    if (exp_fd) e = q_fd.pop_front();
    if (en === 1'b1) begin
      en_cnt[d]++;
      if (d == 0) got0.push_back(fb);
      else got1.push_back(fb);
      if (toggle_chk) chk("no_back_to_back_enable", WIN_W'(prev_en[d]), '0);
    end
    if (fd === 1'b1) fd_cnt[d]++;
    prev_en[d] = (en === 1'b1);
  endtask

  // Monitor: compare every DUT output against the scoreboard on the falling edge.
  always @(negedge clk) begin
    mon(0, bus0.FilterBuffer, bus0.enable, bus0.frameDone);
    mon(1, bus1.FilterBuffer, bus1.enable, bus1.frameDone);
  end

  task automatic step(input int d, input bit s, input bit v, input logic [7:0] p);
    bus0.sof      = (d == 0) && s;
    bus0.pixValid = (d == 0) && v;
    bus0.pixIn    = p;
    bus1.sof      = (d == 1) && s;
    bus1.pixValid = (d == 1) && v;
    bus1.pixIn    = p;
    @(posedge clk);
    #1;
    if (v) model_accept(d, s, p);
  endtask

  task automatic do_reset(input bit v);
    bus0.sof = 1'b0; bus0.pixValid = v; bus0.pixIn = 8'h55;
    bus1.sof = 1'b0; bus1.pixValid = 1'b0; bus1.pixIn = 8'h55;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus0.pixValid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mrow[d] = 0;
      mcol[d] = 0;
    end
    q_win.delete();
    q_fd.delete();
    chk("reset_fb0", bus0.FilterBuffer, '0);
    chk("reset_en0", WIN_W'(bus0.enable), '0);
    chk("reset_fd0", WIN_W'(bus0.frameDone), '0);
    chk("reset_fb1", bus1.FilterBuffer, '0);
    chk("reset_en1", WIN_W'(bus1.enable), '0);
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      en_cnt[d] = 0;
      fd_cnt[d] = 0;
    end
    got0.delete();
    got1.delete();
  endtask

  task automatic send_frame(input int d, input int base, input bit tog);
    for (int r = 0; r < H[d]; r++) begin
      for (int c = 0; c < W[d]; c++) begin
        step(d, (r == 0 && c == 0), 1'b1, 8'(base + r * 16 + c));
        if (tog) step(d, 1'b0, 1'b0, 8'($urandom));
      end
    end
  endtask

  task automatic drain();
    repeat (3) step(0, 1'b0, 1'b0, 8'h00);
    chk("scoreboard_windows_empty", WIN_W'(q_win.size()), '0);
    chk("scoreboard_frameDone_empty", WIN_W'(q_fd.size()), '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [WIN_W-1:0] w_first;
    logic [WIN_W-1:0] w_f2;
    logic [WIN_W-1:0] w;
    w_first = 72'h00_01_02_10_11_12_20_21_22;
    w_f2    = 72'h80_81_82_90_91_92_A0_A1_A2;
    bus0.sof = 1'b0; bus0.pixValid = 1'b0; bus0.pixIn = '0;
    bus1.sof = 1'b0; bus1.pixValid = 1'b0; bus1.pixIn = '0;

    // Test 1: one continuous frame.
    do_reset(1'b0);
    clear_counts();
    send_frame(0, 0, 1'b0);
    drain();
    chk("t1_enable_count", WIN_W'(en_cnt[0]), WIN_W'(36));
    chk("t1_frameDone_count", WIN_W'(fd_cnt[0]), WIN_W'(1));
    chk("t1_first_window", got0[0], w_first);

    // Test 2: pixValid toggling.
    clear_counts();
    toggle_chk = 1'b1;
    send_frame(0, 0, 1'b1);
    drain();
    toggle_chk = 1'b0;
    chk("t2_enable_count", WIN_W'(en_cnt[0]), WIN_W'(36));
    chk("t2_first_window", got0[0], w_first);

    // Test 3: two back-to-back frames.
    clear_counts();
    send_frame(0, 0, 1'b0);
    send_frame(0, 8'h80, 1'b0);
    drain();
    chk("t3_enable_count", WIN_W'(en_cnt[0]), WIN_W'(72));
    chk("t3_frameDone_count", WIN_W'(fd_cnt[0]), WIN_W'(2));
    chk("t3_frame2_first_window", got0[36], w_f2);

    // Test 4: sof in the middle of a frame at (4,3).
    clear_counts();
    for (int i = 0; i < 4 * 8 + 3; i++) step(0, (i == 0), 1'b1, 8'((i / 8) * 16 + (i % 8)));
    send_frame(0, 0, 1'b0);
    drain();
    chk("t4_enable_count", WIN_W'(en_cnt[0]), WIN_W'(49));
    chk("t4_frameDone_count", WIN_W'(fd_cnt[0]), WIN_W'(1));
    chk("t4_new_frame_first_window", got0[13], w_first);

    // Test 5: reset at (5,5), then a fresh frame.
    clear_counts();
    for (int i = 0; i < 5 * 8 + 5; i++) step(0, (i == 0), 1'b1, 8'((i / 8) * 16 + (i % 8)));
    do_reset(1'b1);
    clear_counts();
    send_frame(0, 0, 1'b0);
    drain();
    chk("t5_enable_count", WIN_W'(en_cnt[0]), WIN_W'(36));
    chk("t5_frameDone_count", WIN_W'(fd_cnt[0]), WIN_W'(1));
    chk("t5_first_window", got0[0], w_first);

    // Test 6: 5x3 instance, two frames.
    clear_counts();
    send_frame(1, 0, 1'b0);
    send_frame(1, 0, 1'b0);
    drain();
    chk("t6_enable_count", WIN_W'(en_cnt[1]), WIN_W'(6));
    chk("t6_frameDone_count", WIN_W'(fd_cnt[1]), WIN_W'(2));
    for (int k = 0; k < 3; k++) begin
      w = got1[k];
      chk($sformatf("t6_bottom_right_%0d", k), WIN_W'(w[7:0]), WIN_W'(8'h22 + k));
    end

    // Test 7: random pixels, random gaps and occasional sof on both instances.
    do_reset(1'b0);
    clear_counts();
    repeat (300) step(0, ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
    drain();
    repeat (150) step(1, ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
